run_ctrl: RTL
=============

// Module: run_ctrl
// PURPOSE
//  Run/halt/single-step sequencer for the soft MPU core. Replaces the gated-clock halt scheme with
//  a cpu_ce clock enable, so the datapath and controller stay on clk. Turns start/restart/step
//  buttons into synchronous reset, run, pause, single-step and PC-breakpoint control.
//  Sits in top, between the button pins and the datapath/controller.
// PARAMETERS
//  ADDR_W   8   width of pc and bp_addr
//  CNT_W    16  width of the retired-instruction counter icount
//  RST_CYC  2   number of cycles cpu_rst is held in RESET (must be >= 1)
// PORTS
//  clk        in   1       system clock; all logic on the rising edge
//  rst        in   1       asynchronous, active-low reset
//  start      in   1       button, asynchronous level: run / pause / resume
//  restart    in   1       button, asynchronous level: reset the core to IDLE
//  step       in   1       button, asynchronous level: execute exactly one instruction
//  halt       in   1       core halt flag (controller halt state)
//  instr_done in   1       one-cycle pulse at each instruction boundary (IR load)
//  pc         in   ADDR_W  core PC, valid while instr_done is high
//  bp_en      in   1       breakpoint enable
//  bp_addr    in   ADDR_W  breakpoint PC
//  cpu_ce     out  1       clock enable to the datapath and controller
//  cpu_rst    out  1       synchronous active-high reset to the core
//  state      out  3       current FSM state (encoding below)
//  cause      out  2       stop cause: 0 none, 1 user pause, 2 breakpoint, 3 step
//  icount     out  CNT_W   retired-instruction count
// BEHAVIOUR
//  - Buttons pass through a 2-flop synchronizer and a rising-edge detector. Each press gives one
//    1-cycle event (start_e, restart_e, step_e), 3 cycles after the pin edge.
//  - States: IDLE=0, RESET=1, RUN=2, STEP=3, STOP=4, HALT=5.
//  - On rst low: state=IDLE, cpu_ce=0, cpu_rst=0, cause=0, icount=0, synchronizers cleared.
//  - Event priority each cycle: restart_e > halt > breakpoint > start_e/step_e.
//  - restart_e in any state: go to RESET with target=IDLE.
//  - IDLE:
//     * start_e -> RESET with target=RUN
//     * step_e  -> RESET with target=STEP
//  - RESET: cpu_rst=1 and cpu_ce=1 for RST_CYC cycles; icount=0 and cause=0; then go to target.
//  - RUN: cpu_ce=1.
//     * halt=1 -> HALT
//     * instr_done & bp_en & pc==bp_addr & !bp_skip -> STOP, cause=2
//     * start_e -> STOP, cause=1
//     * step_e ignored
//  - STEP: cpu_ce=1.
//     * halt -> HALT
//     * the first instr_done -> STOP, cause=3; the breakpoint is not checked
//  - STOP: cpu_ce=0.
//     * start_e -> RUN
//     * step_e  -> STEP
//     * on leaving STOP, set bp_skip=1
//  - bp_skip clears at the next instr_done. Resuming at a breakpoint PC therefore does not
//    re-trigger immediately.
//  - HALT: cpu_ce=0. Only restart_e leaves HALT. start_e and step_e are ignored.
//  - cpu_ce = (state in RESET/RUN/STEP) & !(halt & state in RUN/STEP). It is combinational on
//    halt, so the core gets no clock-enabled edge in the cycle halt is first seen.
//  - Breakpoint/step stops take effect on the edge after the instr_done pulse, so the IR-load
//    cycle completes.
//  - icount increments on instr_done & cpu_ce & !cpu_rst and saturates at all-ones.
//  - instr_done while cpu_ce=0 is ignored.
//  - cause holds until the next RESET or the next stop.
//  - rst asserted mid-run: immediate return to IDLE. The core is not reset until the next start.
// STRUCTURE
//  - Package run_ctrl_pkg holds the state codes (S_IDLE..S_HALT) and cause codes
//    (C_NONE, C_PAUSE, C_BP, C_STEP).
//  - One sub-module, btn_edge: 2-flop synchronizer plus rising-edge pulse, same clk and rst.
//    It is instantiated 3x.
//  - FSM, RESET-cycle counter, bp_skip flag and icount are in run_ctrl.
// TESTING
//  1. Release rst, press start:
//     * cpu_rst high exactly 2 cycles, then state=2 and cpu_ce=1
//     * 4 instr_done pulses -> icount=4
//  2. bp_en=1, bp_addr=8'h10; instr_done with pc=8'h10 in RUN:
//     * next cycle state=4, cause=2, cpu_ce=0
//     * start resumes; the next instr_done at pc=8'h10 does not stop; the one after that does
//  3. From STOP press step:
//     * cpu_ce=1 until one instr_done, then state=4, cause=3, icount +1
//     * a second step press repeats this
//  4. halt rises in RUN:
//     * cpu_ce=0 in the same cycle, state=5 next cycle
//     * start and step ignored
//     * restart -> RESET (2 cycles) -> IDLE, icount=0
//  5. Same cycle: restart event, halt=1 and a breakpoint match:
//     * state=1 (restart wins)
//     * drop rst mid-RUN: all outputs at reset values asynchronously

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared state and stop-cause encodings for the run/halt/single-step sequencer.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_STOP  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    C_NONE  = 2'd0,
    C_PAUSE = 2'd1,
    C_BP    = 2'd2,
    C_STEP  = 2'd3
  } cause_e;

endpackage

// File: rtl/run_ctrl_btn_edge.sv
// Button conditioner: 2-flop synchronizer followed by a rising-edge detector.
// The pulse is combinational from the last two flops, so the FSM acts 3 edges after the pin rises.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/run_ctrl.sv
// Run/halt/single-step sequencer: drives the core clock enable and synchronous reset
// from the start/restart/step buttons, the core halt flag and a PC breakpoint.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              restart,
  input  logic              step,
  input  logic              halt,
  input  logic              instr_done,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_ce,
  output logic              cpu_rst,
  output logic [2:0]        state,
  output logic [1:0]        cause,
  output logic [CNT_W-1:0]  icount
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RST_CYC - 1);

  logic start_e, restart_e, step_e;

  btn_edge u_start   (.clk(clk), .rst(rst), .btn_i(start),   .pulse_o(start_e));
  btn_edge u_restart (.clk(clk), .rst(rst), .btn_i(restart), .pulse_o(restart_e));
  btn_edge u_step    (.clk(clk), .rst(rst), .btn_i(step),    .pulse_o(step_e));

  state_e            state_q, state_d, target_q, target_d, go_tgt;
  cause_e            cause_q, cause_d;
  logic [RCW-1:0]    rcnt_q, rcnt_d;
  logic              bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0]  icount_q, icount_d;
  logic              running, instr_ok, bp_hit, go_rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      target_q  <= S_IDLE;
      cause_q   <= C_NONE;
      rcnt_q    <= '0;
      bp_skip_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cause_q   <= cause_d;
      rcnt_q    <= rcnt_d;
      bp_skip_q <= bp_skip_d;
      icount_q  <= icount_d;
    end
  end

  // Halt masks the enable combinationally so the core sees no enabled edge once halted.
  assign running  = (state_q == S_RUN) || (state_q == S_STEP);
  assign cpu_rst  = (state_q == S_RESET);
  assign cpu_ce   = ((state_q == S_RESET) || running) && !(halt && running);
  assign instr_ok = instr_done && cpu_ce && !cpu_rst;
  assign bp_hit   = instr_done && bp_en && (pc == bp_addr) && !bp_skip_q;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cause_d   = cause_q;
    rcnt_d    = rcnt_q;
    bp_skip_d = bp_skip_q;
    icount_d  = icount_q;
    go_rst    = restart_e;
    go_tgt    = S_IDLE;

    if (instr_ok) begin
      bp_skip_d = 1'b0;
      if (icount_q != '1) icount_d = icount_q + CNT_W'(1);
    end

    if (!restart_e) begin
      unique case (state_q)
        S_IDLE: begin
          if (start_e) begin
            go_rst = 1'b1;
            go_tgt = S_RUN;
          end else if (step_e) begin
            go_rst = 1'b1;
            go_tgt = S_STEP;
          end
        end
        S_RESET: begin
          icount_d = '0;
          if (rcnt_q == RC_LAST) state_d = target_q;
          else                   rcnt_d  = rcnt_q + RCW'(1);
        end
        S_RUN: begin
          if (halt) begin
            state_d = S_HALT;
          end else if (bp_hit) begin
            state_d = S_STOP;
            cause_d = C_BP;
          end else if (start_e) begin
            state_d = S_STOP;
            cause_d = C_PAUSE;
          end
        end
        S_STEP: begin
          if (halt) begin
            state_d = S_HALT;
          end else if (instr_done) begin
            state_d = S_STOP;
            cause_d = C_STEP;
          end
        end
        S_STOP: begin
          if (start_e) begin
            state_d   = S_RUN;
            bp_skip_d = 1'b1;
          end else if (step_e) begin
            state_d   = S_STEP;
            bp_skip_d = 1'b1;
          end
        end
        S_HALT: ;
        default: state_d = S_IDLE;
      endcase
    end

    if (go_rst) begin
      state_d   = S_RESET;
      target_d  = go_tgt;
      rcnt_d    = '0;
      cause_d   = C_NONE;
      icount_d  = '0;
      bp_skip_d = 1'b0;
    end
  end

  assign state  = state_q;
  assign cause  = cause_q;
  assign icount = icount_q;

endmodule
